// File: rtl/cnu_pkg.sv
// cnu_pkg: shared types and helper functions for the serial min-sum check
// node unit (cnu_minsum_serial) and its min tracker.
//
// Contents:
//   cnu_state_t  - FSM state encoding {COLLECT, EMIT}
//   maxmag()     - largest magnitude of a two's-complement value of a given width
//   sat_abs()    - saturating absolute value (most negative value -> maxmag)
//   offset_sub() - offset subtraction clamped at zero
//
// The helpers work on 64-bit containers so one definition serves every WIDTH
// parameter. Callers sign-extend into 64 bits and slice the result back down,
// which limits WIDTH to the range 2..63.
package cnu_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cnu_state_t;

    localparam int CNU_MAXW = 64;

    // 2^(width-1) - 1
    function automatic logic [63:0] maxmag(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // x is the operand sign-extended to 64 bits. The only value whose negation
    // exceeds maxmag is -2^(width-1); it saturates instead of wrapping.
    function automatic logic [63:0] sat_abs(input logic [63:0] x, input int width);
        logic [63:0] neg;
        neg = ~x + 64'd1;
        if (!x[63]) return x;
        if (neg > maxmag(width)) return maxmag(width);
        return neg;
    endfunction

    // Offset min-sum magnitude: never wraps below zero.
    function automatic logic [63:0] offset_sub(input logic [63:0] m, input logic [63:0] off);
        return (m > off) ? (m - off) : 64'd0;
    endfunction

endpackage

// File: rtl/cnu_min_tracker.sv
// cnu_min_tracker: running two-minimum search over one check-node frame.
//
// Keeps the smallest magnitude (min1), the second smallest (min2), the edge
// index of min1 (idx) and the XOR of all input signs (parity).
//
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - return to the empty-frame state (min1 = min2 = MAXMAG)
//   en        - fold one message (mag, sign, pos) into the running result
//   mag       - saturated magnitude, WIDTH-1 bits unsigned
//   sign      - message sign bit
//   pos       - edge index of the message
//   min1/min2/idx/parity - registered results
//
// Strict comparisons: a tie with min1 keeps the earlier index and lands in min2,
// so min2 may equal min1.
module cnu_min_tracker
    import cnu_pkg::*;
#(
    parameter int DEGREE = 6,
    parameter int WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [WIDTH-2:0]          mag,
    input  logic                      sign,
    input  logic [$clog2(DEGREE)-1:0] pos,
    output logic [WIDTH-2:0]          min1,
    output logic [WIDTH-2:0]          min2,
    output logic [$clog2(DEGREE)-1:0] idx,
    output logic                      parity
);

    localparam logic [63:0]      MAX64  = maxmag(WIDTH);
    localparam logic [WIDTH-2:0] MAXMAG = MAX64[WIDTH-2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min1   <= MAXMAG;
            min2   <= MAXMAG;
            idx    <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            min1   <= MAXMAG;
            min2   <= MAXMAG;
            idx    <= '0;
            parity <= 1'b0;
        end else if (en) begin
            parity <= parity ^ sign;
            if (mag < min1) begin
                min2 <= min1;
                min1 <= mag;
                idx  <= pos;
            end else if (mag < min2) begin
                min2 <= mag;
            end
        end
    end

endmodule

// File: rtl/cnu_minsum_serial.sv
// cnu_minsum_serial: serial min-sum LDPC check node unit.
//
// Collects DEGREE signed Q messages (one per q handshake), then emits DEGREE
// R messages (one per r handshake) in the same edge order. R for edge i carries
// the minimum magnitude over all other edges and the product of their signs.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds data stable while
// valid is high and ready is low. q_ready is high only while collecting;
// r_valid is high only while emitting.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   q_in      - signed Q message, WIDTH bits
//   q_valid   - q_in valid
//   q_ready   - unit can accept q_in
//   r_out     - signed R message, WIDTH bits
//   r_idx     - edge index of r_out
//   r_valid   - r_out valid
//   r_ready   - downstream accepts r_out
//   r_last    - r_out is edge DEGREE-1
//   dbg_state - FSM state (0 = COLLECT, 1 = EMIT)
//
// Build option: define CNU_OFFSET_EN for offset min-sum (emitted magnitude is
// reduced by OFFSET, clamped at zero). Without it the unit is plain min-sum and
// OFFSET has no effect.
//
// WIDTH must lie in 2..63 and DEGREE must be >= 2.
module cnu_minsum_serial
    import cnu_pkg::*;
#(
    parameter int DEGREE = 6,
    parameter int WIDTH  = 32,
    parameter int OFFSET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          q_in,
    input  logic                      q_valid,
    output logic                      q_ready,
    output logic [WIDTH-1:0]          r_out,
    output logic [$clog2(DEGREE)-1:0] r_idx,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic                      r_last,
    output logic                      dbg_state
);

    localparam int             IW   = $clog2(DEGREE);
    localparam int             MW   = WIDTH - 1;
    localparam logic [IW-1:0]  LAST = IW'(DEGREE - 1);

    cnu_state_t         state, state_n;
    logic [IW-1:0]      cnt, cnt_n;
    logic               q_ready_n, r_valid_n;
    logic               trk_en, trk_clr;
    logic [DEGREE-1:0]  signs;

    logic [MW-1:0]      min1, min2;
    logic [IW-1:0]      idx;
    logic               parity;

    // ---------------- input magnitude ----------------
    logic [63:0]        q_ext, abs64;
    logic [MW-1:0]      mag;

    assign q_ext = {{(CNU_MAXW - WIDTH){q_in[WIDTH-1]}}, q_in};
    assign abs64 = sat_abs(q_ext, WIDTH);
    assign mag   = abs64[MW-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= COLLECT;
            cnt     <= '0;
            q_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            q_ready <= q_ready_n;
            r_valid <= r_valid_n;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        q_ready_n = q_ready;
        r_valid_n = r_valid;
        trk_en    = 1'b0;
        trk_clr   = 1'b0;
        case (state)
            COLLECT: begin
                // q_ready comes up on the first edge after reset release and
                // stays up until the last Q of the frame is taken.
                q_ready_n = 1'b1;
                if (q_valid && q_ready) begin
                    trk_en = 1'b1;
                    if (cnt == LAST) begin
                        cnt_n     = '0;
                        q_ready_n = 1'b0;
                        r_valid_n = 1'b1;
                        state_n   = EMIT;
                    end else begin
                        cnt_n = cnt + IW'(1);
                    end
                end
            end
            EMIT: begin
                if (r_valid && r_ready) begin
                    if (cnt == LAST) begin
                        cnt_n     = '0;
                        r_valid_n = 1'b0;
                        q_ready_n = 1'b1;
                        trk_clr   = 1'b1;
                        state_n   = COLLECT;
                    end else begin
                        cnt_n = cnt + IW'(1);
                    end
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

    // ---------------- sign register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signs <= '0;
        end else if (trk_clr) begin
            signs <= '0;
        end else if (trk_en) begin
            signs[cnt] <= q_in[WIDTH-1];
        end
    end

    // ---------------- min tracker ----------------
    cnu_min_tracker #(
        .DEGREE (DEGREE),
        .WIDTH  (WIDTH)
    ) u_trk (
        .clk    (clk),
        .rst    (rst),
        .clr    (trk_clr),
        .en     (trk_en),
        .mag    (mag),
        .sign   (q_in[WIDTH-1]),
        .pos    (cnt),
        .min1   (min1),
        .min2   (min2),
        .idx    (idx),
        .parity (parity)
    );

    // ---------------- output mux ----------------
    // Everything below depends only on registers, so r_out/r_idx/r_last hold
    // steady while the downstream stalls. Gating with r_valid keeps the outputs
    // at zero outside EMIT, including during reset.
    logic [MW-1:0]      m_sel, m_emit;
    logic [63:0]        m64, em64;
    logic               s_out;
    logic [WIDTH-1:0]   mag_w, r_val;

    assign m_sel = (cnt == idx) ? min2 : min1;
    assign m64   = {{(CNU_MAXW - MW){1'b0}}, m_sel};

`ifdef CNU_OFFSET_EN
    assign em64 = offset_sub(m64, 64'(OFFSET));
`else
    localparam int unused_offset = OFFSET;
    assign em64 = m64;
`endif

    assign m_emit = em64[MW-1:0];
    assign s_out  = parity ^ signs[cnt];
    assign mag_w  = {1'b0, m_emit};

    always_comb begin
        r_val = '0;
        if (m_emit != '0) begin
            // m_emit <= MAXMAG, so the negation cannot overflow.
            r_val = s_out ? (~mag_w + WIDTH'(1)) : mag_w;
        end
    end

    assign r_out     = r_valid ? r_val : '0;
    assign r_idx     = r_valid ? cnt : '0;
    assign r_last    = r_valid & (cnt == LAST);
    assign dbg_state = state;

    logic unused_bits;
    assign unused_bits = ^{abs64[63:MW], em64[63:MW]};

endmodule

// File: tb/tb_cnu_minsum_serial.sv
// tb_cnu_minsum_serial: directed bench for cnu_minsum_serial (DEGREE=6, WIDTH=32).
// Expected R values come from a brute-force reference (min over the other
// edges, product of the other signs) pushed onto exp_q as each frame is driven
// and popped as R handshakes complete. Build with CNU_OFFSET_EN to check the
// offset variant against the same reference with the offset applied.
module tb_cnu_minsum_serial;
  import cnu_pkg::*;

  localparam int DEG    = 6;
  localparam int W      = 32;
  localparam int OFFSET = 1;
  localparam longint MAXM = 64'h7fffffff;

  typedef logic [W-1:0] frame_t [DEG];

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] q_in;
  logic         q_valid;
  logic         q_ready;
  logic [W-1:0] r_out;
  logic [2:0]   r_idx;
  logic         r_valid;
  logic         r_ready;
  logic         r_last;
  logic         dbg_state;

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];

  cnu_minsum_serial #(.DEGREE(DEG), .WIDTH(W), .OFFSET(OFFSET)) dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .r_out     (r_out),
    .r_idx     (r_idx),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_last    (r_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: R for edge i from the other DEGREE-1 messages.
  function automatic logic [W-1:0] model_r(input frame_t f, input int i);
    longint mn;
    longint v;
    longint a;
    bit     s;
    mn = MAXM;
    s  = 1'b0;
    for (int j = 0; j < DEG; j++) begin
      if (j != i) begin
        v = longint'($signed(f[j]));
        a = (v < 0) ? -v : v;
        if (a > MAXM) a = MAXM;
        if (a < mn) mn = a;
        s ^= f[j][W-1];
      end
    end
`ifdef CNU_OFFSET_EN
    mn = (mn > OFFSET) ? mn - OFFSET : 0;
`endif
    if (mn == 0) return '0;
    return s ? W'(-mn) : W'(mn);
  endfunction

  // ---------------- drivers ----------------
  // All drivers are entered and left at a falling edge.
  task automatic send_q(input logic [W-1:0] v);
    int t;
    t = 0;
    q_in    = v;
    q_valid = 1'b1;
    while (q_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("q_ready timeout", {31'b0, q_ready}, 1);
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int max_gap);
    for (int i = 0; i < DEG; i++) exp_q.push_back(model_r(f, i));
    for (int i = 0; i < DEG; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        check("gap q_ready", {31'b0, q_ready}, 1);
      end
      send_q(f[i]);
    end
    check("latency r_valid", {31'b0, r_valid}, 1);
    check("emit q_ready", {31'b0, q_ready}, 0);
    check("emit state", {31'b0, dbg_state}, W'(EMIT));
  endtask

  task automatic recv_frame(input int stall_at, input int stall_len);
    logic [W-1:0] hold_out;
    logic [2:0]   hold_idx;
    logic [W-1:0] exp;
    int t;
    for (int k = 0; k < DEG; k++) begin
      if (k == stall_at) begin
        r_ready  = 1'b0;
        hold_out = r_out;
        hold_idx = r_idx;
        for (int c = 0; c < stall_len; c++) begin
          @(negedge clk);
          check("stall r_out", r_out, hold_out);
          check("stall r_idx", {29'b0, r_idx}, {29'b0, hold_idx});
          check("stall r_valid", {31'b0, r_valid}, 1);
          check("stall q_ready", {31'b0, q_ready}, 0);
        end
      end
      r_ready = 1'b1;
      t = 0;
      while (r_valid !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("r_valid timeout", {31'b0, r_valid}, 1);
      if (exp_q.size() == 0) begin
        check("scoreboard empty", 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("r_out[%0d]", k), r_out, exp);
      end
      check($sformatf("r_idx[%0d]", k), {29'b0, r_idx}, W'(k));
      check($sformatf("r_last[%0d]", k), {31'b0, r_last}, W'(k == DEG - 1));
      check("emit q_ready", {31'b0, q_ready}, 0);
      @(negedge clk);
    end
    r_ready = 1'b0;
    check("post r_valid", {31'b0, r_valid}, 0);
    check("post q_ready", {31'b0, q_ready}, 1);
    check("post state", {31'b0, dbg_state}, W'(COLLECT));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    frame_t f1, f3a, f3b, f4, fr;

    f1  = '{-2, -4, 5, -6, 7, 8};
    f3a = '{3, -3, 9, 9, 9, 9};
    f3b = '{0, 5, 5, 5, 5, 5};
    f4  = '{32'h80000000, 100, 100, 100, 100, 100};

    rst     = 1'b0;
    q_in    = '0;
    q_valid = 1'b0;
    r_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst q_ready", {31'b0, q_ready}, 0);
    check("rst r_valid", {31'b0, r_valid}, 0);
    check("rst r_out", r_out, 0);
    check("rst r_last", {31'b0, r_last}, 0);
    check("rst min1", {1'b0, dut.u_trk.min1}, W'(MAXM));
    check("rst min2", {1'b0, dut.u_trk.min2}, W'(MAXM));
    rst = 1'b1;
    #1 check("release q_ready low", {31'b0, q_ready}, 0);
    @(negedge clk);
    check("release q_ready high", {31'b0, q_ready}, 1);

    // basic frame (offset variant when built with CNU_OFFSET_EN)
    send_frame(f1, 0);
    recv_frame(-1, 0);

    // ties and zero
    send_frame(f3a, 0);
    check("tie idx", {29'b0, dut.u_trk.idx}, 0);
    check("tie min1", {1'b0, dut.u_trk.min1}, 3);
    check("tie min2", {1'b0, dut.u_trk.min2}, 3);
    check("tie parity", {31'b0, dut.u_trk.parity}, 1);
    recv_frame(-1, 0);
    send_frame(f3b, 0);
    recv_frame(-1, 0);

    // saturation
    send_frame(f4, 0);
    check("sat min1", {1'b0, dut.u_trk.min1}, 100);
    check("sat idx", {29'b0, dut.u_trk.idx}, 1);
    recv_frame(-1, 0);

    // backpressure and gaps
    send_frame(f1, 3);
    recv_frame(2, 3);

    // reset mid-frame
    send_q(f1[0]);
    send_q(f1[1]);
    send_q(f1[2]);
    rst = 1'b0;
    #1;
    check("abort q_ready", {31'b0, q_ready}, 0);
    check("abort r_valid", {31'b0, r_valid}, 0);
    check("abort r_out", r_out, 0);
    check("abort r_idx", {29'b0, r_idx}, 0);
    check("abort r_last", {31'b0, r_last}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort release q_ready low", {31'b0, q_ready}, 0);
    @(negedge clk);
    check("abort release q_ready high", {31'b0, q_ready}, 1);
    check("abort r_valid idle", {31'b0, r_valid}, 0);
    send_frame(f1, 0);
    recv_frame(-1, 0);

    // random frames
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < DEG; i++) fr[i] = W'(int'($urandom_range(0, 40)) - 20);
      send_frame(fr, 2);
      recv_frame(int'($urandom_range(0, DEG - 1)), int'($urandom_range(1, 3)));
    end

    check("scoreboard drained", W'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
